display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexing scan controller for the 4-digit 7-segment display.
- Double-buffers a 16-bit BCD value plus per-digit decimal points.
- Steps the digit select through 0..3 at a programmable rate, inserting an anti-ghosting blank interval at the start of each digit slot.
- Drives the existing 4:1 display mux (num3..num0, digit) and the one-hot digit enables; commits new values only at frame boundaries so the display never tears.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all digit enables off. Must be < SCAN_DIV; 0 is legal.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scan enable; low blanks the display and idles the controller
- val_in  in  16  BCD value {d3,d2,d1,d0}
- dp_in  in  4  decimal point per digit, bit k = digit k
- load  in  1  request to update the display value
- load_ack  out  1  one-cycle pulse on the cycle the value becomes visible
- num3, num2, num1, num0  out  4 each  committed digits, to the display mux
- digit  out  2  current digit select, to the display mux
- decimal  out  1  committed dp bit of the current digit
- digit_en  out  4  one-hot active-high digit enable; 0 when blanked
- blank  out  1  high whenever digit_en == 0
- frame_start  out  1  one-cycle pulse at slot cycle 0 of digit 0

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), and dominates all other inputs.
- Reset values:
  - state = IDLE
  - shadow value, shadow dp, pending flag = 0
  - num3..num0 = 0, digit = 0, decimal = 0
  - digit_en = 0, blank = 1
  - load_ack = 0, frame_start = 0
- All outputs are registered.
- States:
  - IDLE: counters cleared, digit = 0, blank = 1.
  - BLANK: slot cycles 0 .. BLANK_CYCLES-1, digit_en = 0.
  - SHOW: slot cycles BLANK_CYCLES .. SCAN_DIV-1, digit_en = 1 << digit.
- Transitions:
  - IDLE -> BLANK when enable = 1. With BLANK_CYCLES = 0, go directly to SHOW. Enter at slot cycle 0 of digit 0; frame_start pulses in that cycle.
  - BLANK -> SHOW after BLANK_CYCLES cycles.
  - SHOW -> next slot at the end of slot cycle SCAN_DIV-1: digit increments, 3 wraps to 0, and the slot counter returns to 0 in BLANK (or SHOW if BLANK_CYCLES = 0).
  - Any state -> IDLE on the cycle after enable = 0 is sampled. Outputs blank immediately on that transition.
- Slot counter: width $clog2(SCAN_DIV); counts 0 .. SCAN_DIV-1, then wraps.
- Frame period: 4*SCAN_DIV cycles.
- digit changes on slot cycle 0. decimal follows digit in the same cycle.
- Load and commit:
  - load = 1 captures val_in/dp_in into the pending register and sets the pending flag.
  - A later load before commit overwrites pending; newest wins.
  - Commit copies pending to the shadow registers (num3..num0, dp) on the clock edge entering slot cycle 0 of digit 0. frame_start and load_ack both pulse in that cycle, and the pending flag clears.
  - In IDLE, commit happens on the cycle after load, so load_ack has 1-cycle latency.
  - If load = 1 in the same cycle a commit would occur, val_in/dp_in are committed directly and load_ack pulses.
  - No commit occurs mid-frame.
- BCD values > 9 pass through unchanged; the controller does no validation.
- If enable falls while a load is pending, the pending value commits in IDLE on the next cycle.
- Reset mid-frame discards both the pending and shadow values.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - In SHOW for digit k (k = 3, 2, 1), digit_en stays 0 and blank stays 1 if every committed digit j >= k is 0 and the dp bit of every digit j >= k is 0.
  - Digit 0 is never suppressed.
  - Slot timing, digit, num and decimal outputs are unchanged.
- When undefined: all four digits are always shown.

Test Plan:
1. SCAN_DIV=8, BLANK_CYCLES=2, enable=1 after reset:
   - digit sequence 0,1,2,3,0 with 8 cycles each.
   - digit_en = 0000 for 2 cycles, then 0001 for 6 cycles (likewise 0010, 0100, 1000).
   - frame_start every 32 cycles.
2. Load mid-frame: at frame cycle 10, load with val_in=16'h1234, dp_in=4'b0100.
   - num3..num0 remain 0 until the next frame_start.
   - At frame_start: num3..num0 = 1,2,3,4; load_ack pulses the same cycle; decimal = 1 only while digit = 2.
3. Back-to-back loads: load 16'h1111 at frame cycle 5, then 16'h2222 at frame cycle 20.
   - One commit of 2222 at the next frame; exactly one load_ack.
4. Load coincident with the commit cycle: val_in=16'h9876 committed immediately; load_ack pulses in that cycle.
5. Enable drop mid-slot, at digit 2, cycle 5:
   - next cycle: digit_en = 0, digit = 0, state IDLE.
   - load 16'h0042 in IDLE -> load_ack and num outputs update 1 cycle later.
   - re-enable -> frame_start pulses and the scan restarts at digit 0.
6. LEADING_ZERO_BLANK_EN with value 16'h0042, dp=0:
   - digit_en is never 1000 or 0100; digits 1 and 0 are shown.
   - With dp_in=4'b1000, digit 3 is shown.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller: double-buffered BCD value with frame-aligned commit.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading all-zero digits.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] val_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  num3,
  output logic [3:0]  num2,
  output logic [3:0]  num1,
  output logic [3:0]  num0,
  output logic [1:0]  digit,
  output logic        decimal,
  output logic [3:0]  digit_en,
  output logic        blank,
  output logic        frame_start
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t        state, state_n;
  logic [SW-1:0] slot, slot_n;
  logic [1:0]    digit_n;
  logic          frame_n;
  logic          commit;
  logic          pending;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic [3:0]    dp_sh;
  logic [15:0]   shadow_n;
  logic [3:0]    dp_n;
  logic [3:0]    en_n;
  logic          suppress;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      digit       <= 2'd0;
      pending     <= 1'b0;
      pend_val    <= 16'h0000;
      pend_dp     <= 4'h0;
      num3        <= 4'h0;
      num2        <= 4'h0;
      num1        <= 4'h0;
      num0        <= 4'h0;
      dp_sh       <= 4'h0;
      decimal     <= 1'b0;
      digit_en    <= 4'h0;
      blank       <= 1'b1;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      digit       <= digit_n;
      {num3, num2, num1, num0} <= shadow_n;
      dp_sh       <= dp_n;
      decimal     <= dp_n[digit_n];
      digit_en    <= en_n;
      blank       <= (en_n == 4'h0);
      load_ack    <= commit && (load || pending);
      frame_start <= frame_n;
      if (commit) begin
        pending <= 1'b0;
      end else if (load) begin
        pend_val <= val_in;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end
    end
  end

  // Outputs are registered from the next-state values so digit, decimal and
  // digit_en all change on the same edge as the slot counter.
  always_comb begin
    state_n = state;
    slot_n  = slot;
    digit_n = digit;
    frame_n = 1'b0;
    case (state)
      IDLE: begin
        slot_n  = '0;
        digit_n = 2'd0;
        if (enable) begin
          state_n = SLOT_START;
          frame_n = 1'b1;
        end
      end
      default: begin
        if (slot == SLOT_LAST) begin
          slot_n  = '0;
          digit_n = digit + 2'd1;
          state_n = SLOT_START;
          frame_n = (digit == 2'd3);
        end else begin
          slot_n = slot + 1'b1;
          if (state == BLANK && slot == BLANK_LAST)
            state_n = SHOW;
        end
      end
    endcase
    if (!enable) begin
      state_n = IDLE;
      slot_n  = '0;
      digit_n = 2'd0;
      frame_n = 1'b0;
    end

    // A load on the commit edge bypasses the pending register.
    commit   = frame_n || (state == IDLE);
    shadow_n = {num3, num2, num1, num0};
    dp_n     = dp_sh;
    if (commit) begin
      if (load) begin
        shadow_n = val_in;
        dp_n     = dp_in;
      end else if (pending) begin
        shadow_n = pend_val;
        dp_n     = pend_dp;
      end
    end

    suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_n)
      2'd3: suppress = (shadow_n[15:12] == 4'h0) && !dp_n[3];
      2'd2: suppress = (shadow_n[15:8] == 8'h00) && (dp_n[3:2] == 2'b00);
      2'd1: suppress = (shadow_n[15:4] == 12'h000) && (dp_n[3:1] == 3'b000);
      default: suppress = 1'b0;
    endcase
`endif

    en_n = 4'h0;
    if (state_n == SHOW && !suppress)
      en_n = 4'b0001 << digit_n;
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: per-cycle scoreboard from a frame-position
// model, an IDLE load vector table, and hand-written multi-cycle sequences.
module tb_display_scan_ctrl;

  localparam int SD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] val_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  num3, num2, num1, num0;
  logic [1:0]  digit;
  logic        decimal;
  logic [3:0]  digit_en;
  logic        blank;
  logic        frame_start;

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .val_in(val_in), .dp_in(dp_in),
    .load(load), .load_ack(load_ack), .num3(num3), .num2(num2), .num1(num1),
    .num0(num0), .digit(digit), .decimal(decimal), .digit_en(digit_en),
    .blank(blank), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] num;
    logic [1:0]  dig;
    logic        dec;
    logic [3:0]  en;
    logic        blk;
    logic        ack;
    logic        fs;
  } exp_t;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [15:0] exp_num;
    logic        exp_ack;
    logic        exp_dec;
  } vec_t;

  int   checks = 0;
  int   fails  = 0;
  exp_t expq[$];

  bit          m_run;
  int          m_pos;
  logic [15:0] m_num;
  logic [3:0]  m_dp;
  bit          m_pend;
  logic [15:0] m_pval;
  logic [3:0]  m_pdp;
  bit          m_ack;
  bit          m_fs;
  bit          m_was_idle;
  bit          m_hide;
  exp_t        m_e;

  // Reference model: tracks position within the frame rather than a state machine.
  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_pos = 0; m_num = 16'h0; m_dp = 4'h0; m_pend = 0;
      m_pval = 16'h0; m_pdp = 4'h0; m_ack = 0; m_fs = 0;
    end else begin
      m_was_idle = !m_run;
      m_fs = 0;
      m_ack = 0;
      if (!enable) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; m_fs = 1;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        m_fs  = (m_pos == 0);
      end
      if (m_was_idle || m_fs) begin
        if (load) begin
          m_num = val_in; m_dp = dp_in; m_ack = 1;
        end else if (m_pend) begin
          m_num = m_pval; m_dp = m_pdp; m_ack = 1;
        end
        m_pend = 0;
      end else if (load) begin
        m_pval = val_in; m_pdp = dp_in; m_pend = 1;
      end
    end
    m_e.num = m_num;
    m_e.dig = m_run ? 2'(m_pos / SD) : 2'd0;
    m_e.dec = m_dp[m_e.dig];
    m_e.en  = (m_run && (m_pos % SD) >= BL) ? (4'b0001 << m_e.dig) : 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
    m_hide = 1;
    for (int j = int'(m_e.dig); j < 4; j++)
      if (m_num[4*j +: 4] != 4'h0 || m_dp[j]) m_hide = 0;
    if (m_e.dig != 2'd0 && m_hide) m_e.en = 4'h0;
`endif
    m_e.blk = (m_e.en == 4'h0);
    m_e.ack = m_ack;
    m_e.fs  = m_fs;
    expq.push_back(m_e);
  end

  exp_t got;
  exp_t want;

  always @(negedge clk) begin
    got = {num3, num2, num1, num0, digit, decimal, digit_en, blank, load_ack, frame_start};
    checks++;
    if (expq.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard underflow at t=%0t", $time);
    end else begin
      want = expq.pop_front();
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL scoreboard t=%0t got num=%h dig=%0d dec=%b en=%b blk=%b ack=%b fs=%b, expected num=%h dig=%0d dec=%b en=%b blk=%b ack=%b fs=%b",
                 $time, got.num, got.dig, got.dec, got.en, got.blk, got.ack, got.fs,
                 want.num, want.dig, want.dec, want.en, want.blk, want.ack, want.fs);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d);
    load   = ld;
    val_in = v;
    dp_in  = d;
  endtask

  task automatic pulseLoad(input logic [15:0] v, input logic [3:0] d);
    applyStimulus(1'b1, v, d);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Bounded wait until the model says the current cycle is frame position p.
  task automatic waitPos(input int p);
    int n;
    n = 0;
    while (!(m_run && m_pos == p) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(m_run && m_pos == p)) begin
      fails++;
      $display("[TB] FAIL waitPos timeout: got pos %0d, expected %0d", m_pos, p);
    end
  endtask

  vec_t tbl[6];
  int   acks;
  int   bad_en;
  bit   saw_d3;

  initial begin
    tbl[0] = '{1'b1, 16'h0042, 4'b0000, 16'h0042, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 16'h7777, 4'b1111, 16'h0042, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'hABCD, 4'b0001, 16'hABCD, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 16'hF0E9, 4'b1110, 16'hF0E9, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'h1234, 4'b0001, 16'hF0E9, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 16'h0000, 4'b0000, 16'h0000, 1'b1, 1'b0};

    reset = 1'b1; enable = 1'b0;
    applyStimulus(1'b0, 16'h0, 4'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset blank", {31'd0, blank}, 32'd1);
    checkOutput("reset digit_en", {28'd0, digit_en}, 32'd0);
    checkOutput("reset num", {16'd0, num3, num2, num1, num0}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] IDLE load table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].ld, tbl[i].val, tbl[i].dp);
      @(negedge clk);
      checkOutput($sformatf("idle num row%0d", i), {16'd0, num3, num2, num1, num0}, {16'd0, tbl[i].exp_num});
      checkOutput($sformatf("idle ack row%0d", i), {31'd0, load_ack}, {31'd0, tbl[i].exp_ack});
      checkOutput($sformatf("idle dec row%0d", i), {31'd0, decimal}, {31'd0, tbl[i].exp_dec});
    end
    load = 1'b0;

    $display("[TB] scan start and mid-frame load");
    enable = 1'b1;
    @(negedge clk);
    checkOutput("first frame_start", {31'd0, frame_start}, 32'd1);
    checkOutput("first slot blank", {28'd0, digit_en}, 32'd0);
    waitPos(2);
    checkOutput("digit0 shown", {28'd0, digit_en}, 32'h1);
    waitPos(9);
    pulseLoad(16'h1234, 4'b0100);
    waitPos(31);
    checkOutput("no mid-frame commit", {16'd0, num3, num2, num1, num0}, 32'd0);
    @(negedge clk);
    checkOutput("commit 1234", {16'd0, num3, num2, num1, num0}, 32'h1234);
    checkOutput("commit ack", {30'd0, load_ack, frame_start}, 32'h3);
    waitPos(16);
    checkOutput("dp on digit2", {29'd0, digit, decimal}, 32'h5);

    $display("[TB] back-to-back loads");
    waitPos(4);
    pulseLoad(16'h1111, 4'h0);
    waitPos(19);
    pulseLoad(16'h2222, 4'h0);
    acks = 0;
    for (int i = 0; i < FRAME && !(m_run && m_pos == 0); i++) begin
      if (load_ack) acks++;
      @(negedge clk);
    end
    if (load_ack) acks++;
    checkOutput("single ack count", acks, 32'd1);
    checkOutput("newest wins", {16'd0, num3, num2, num1, num0}, 32'h2222);

    $display("[TB] load on commit edge");
    waitPos(31);
    pulseLoad(16'h9876, 4'h0);
    checkOutput("direct commit", {16'd0, num3, num2, num1, num0}, 32'h9876);
    checkOutput("direct ack", {30'd0, load_ack, frame_start}, 32'h3);

    $display("[TB] enable drop and IDLE load");
    waitPos(21);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("drop blank", {25'd0, digit, digit_en, blank}, 32'h1);
    pulseLoad(16'h0042, 4'h0);
    checkOutput("idle commit", {16'd0, num3, num2, num1, num0}, 32'h0042);
    checkOutput("idle ack", {31'd0, load_ack}, 32'd1);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("restart", {29'd0, digit, frame_start}, 32'd1);

    $display("[TB] enable drop with pending load");
    waitPos(3);
    pulseLoad(16'h5555, 4'h0);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("pending not yet", {16'd0, num3, num2, num1, num0}, 32'h0042);
    @(negedge clk);
    checkOutput("pending commit idle", {15'd0, load_ack, num3, num2, num1, num0}, 32'h15555);

    $display("[TB] reset mid-frame");
    pulseLoad(16'h0042, 4'h0);
    enable = 1'b1;
    waitPos(12);
    pulseLoad(16'h7777, 4'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset clears num", {16'd0, num3, num2, num1, num0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pending discarded", {15'd0, load_ack, num3, num2, num1, num0}, 32'd0);

    pulseLoad(16'h0042, 4'h0);
    waitPos(0);
    bad_en = 0;
    saw_d3 = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (digit_en == 4'b1000 || digit_en == 4'b0100) bad_en++;
    end
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("leading zeros hidden", bad_en, 32'd0);
    waitPos(27);
    pulseLoad(16'h0042, 4'b1000);
    waitPos(26);
    checkOutput("dp keeps digit3", {28'd0, digit_en}, 32'h8);
`else
    checkOutput("all digits shown", bad_en, 32'd12);
`endif

    enable = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
